// File: rtl/led_state_uart_tx.sv
// led_state_uart_tx: reports an 8-bit LED vector to the host as a 3-byte UART frame
//   (0xA5, DATA, DATA^0x5A), each byte 8N1 LSB-first.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   bits       in   [7:0] LED vector to report
//   force_send in   one-cycle pulse requesting a frame even if bits are unchanged
//   tx         out  UART serial line, idle high
//   busy       out  high from first start bit through last stop bit of a frame
//   frame_done out  one-cycle pulse in the final cycle of the last stop bit
module led_state_uart_tx #(
    parameter int CLOCK_FREQ       = 12_000_000,
    parameter int BAUD_RATE        = 115_200,
    parameter int HEARTBEAT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bits,
    input  logic       force_send,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_PRE = TW'(CLKS_PER_BIT - 2);
    localparam logic [31:0] HB_LAST = 32'(HEARTBEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [1:0]    byte_idx;
    logic [2:0]    bit_idx;
    logic [7:0]    snapshot;
    logic [7:0]    last_sent;
    logic [7:0]    shreg;
    logic          pending;
    logic [31:0]   hb_cnt;
    logic          hb_hit;
    logic          start;
    logic          bit_end;
    logic [7:0]    cur_byte;

    // The heartbeat hit starts a frame directly from IDLE so that frame starts
    // are spaced exactly HEARTBEAT_CYCLES apart; while busy it only sets pending.
    assign hb_hit   = (HEARTBEAT_CYCLES > 0) && (hb_cnt == HB_LAST);
    assign start    = (state == IDLE) && ((bits != last_sent) || pending || force_send || hb_hit);
    assign bit_end  = timer == T_LAST;
    assign cur_byte = byte_idx == 2'd0 ? 8'hA5 : byte_idx == 2'd1 ? snapshot : snapshot ^ 8'h5A;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            timer      <= '0;
            byte_idx   <= '0;
            bit_idx    <= '0;
            snapshot   <= '0;
            last_sent  <= '0;
            shreg      <= '0;
            pending    <= 1'b1;
            hb_cnt     <= '0;
        end else begin
            // Registered one cycle early so the pulse lands in the last stop cycle.
            frame_done <= (state == STOP) && (byte_idx == 2'd2) && (timer == T_PRE);
            timer      <= (state == IDLE || bit_end) ? '0 : timer + 1'b1;
            if (HEARTBEAT_CYCLES > 0 && !hb_hit)
                hb_cnt <= hb_cnt + 32'd1;
            if (force_send || hb_hit)
                pending <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    state     <= START;
                    tx        <= 1'b0;
                    busy      <= 1'b1;
                    snapshot  <= bits;
                    last_sent <= bits;
                    pending   <= 1'b0;
                    hb_cnt    <= '0;
                    byte_idx  <= '0;
                end
                START: if (bit_end) begin
                    state   <= DATA;
                    bit_idx <= '0;
                    tx      <= cur_byte[0];
                    shreg   <= cur_byte >> 1;
                end
                DATA: if (bit_end) begin
                    bit_idx <= bit_idx + 3'd1;
                    shreg   <= shreg >> 1;
                    tx      <= bit_idx == 3'd7 ? 1'b1 : shreg[0];
                    if (bit_idx == 3'd7)
                        state <= STOP;
                end
                STOP: if (bit_end) begin
                    if (byte_idx == 2'd2) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state    <= START;
                        tx       <= 1'b0;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_state_uart_tx.sv
// tb_led_state_uart_tx: scoreboard bench; a UART decoder pops expected bytes,
//   a second instance with a 1000-cycle heartbeat checks frame start spacing.
module tb_led_state_uart_tx;
    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic       fs_a = 1'b0;
    logic       fs_b = 1'b0;
    logic [7:0] bits_a = 8'h18;
    logic [7:0] bits_b = 8'h33;
    logic       tx_a, busy_a, frame_done_a;
    logic       tx_b, busy_b, frame_done_b;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         sp_q[$];

    led_state_uart_tx #(.CLOCK_FREQ(40), .BAUD_RATE(4), .HEARTBEAT_CYCLES(0)) dut (
        .clk(clk), .rst(rst_a), .bits(bits_a), .force_send(fs_a),
        .tx(tx_a), .busy(busy_a), .frame_done(frame_done_a)
    );

    led_state_uart_tx #(.CLOCK_FREQ(40), .BAUD_RATE(4), .HEARTBEAT_CYCLES(1000)) dut_hb (
        .clk(clk), .rst(rst_b), .bits(bits_b), .force_send(fs_b),
        .tx(tx_b), .busy(busy_b), .frame_done(frame_done_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_frame(input logic [7:0] d);
        exp_q.push_back(8'hA5);
        exp_q.push_back(d);
        exp_q.push_back(d ^ 8'h5A);
    endtask

    // Waits n falling edges, returning early with ab=1 if reset is seen.
    task automatic wait_n(input int n, output bit ab);
        ab = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (rst_a) begin
                ab = 1'b1;
                return;
            end
        end
    endtask

    // UART decoder / scoreboard consumer for the main instance.
    logic [7:0] rx_d;
    logic       rx_stop;
    bit         rx_ab;
    initial forever begin
        @(negedge clk);
        if (!rst_a && tx_a === 1'b0) begin
            wait_n(5, rx_ab);
            if (!rx_ab && tx_a !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL start_bit actual=%b required=0", tx_a);
            end
            for (int i = 0; i < 8; i++) begin
                if (!rx_ab) begin
                    wait_n(10, rx_ab);
                    rx_d[i] = tx_a;
                end
            end
            if (!rx_ab) begin
                wait_n(10, rx_ab);
                rx_stop = tx_a;
            end
            if (!rx_ab) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=%h required=none", rx_d);
                end else begin
                    chk("byte", rx_d, exp_q.pop_front());
                    chk("stop_bit", rx_stop, 1);
                end
            end
        end
    end

    // Frame-level monitor for the main instance.
    int   frames_a = 0;
    int   done_a = 0;
    int   busy_run = 0;
    int   idle_run = 0;
    int   last_gap = -1;
    logic prev_busy = 1'b0;
    logic prev_fd = 1'b0;
    always @(negedge clk) begin
        if (rst_a) begin
            busy_run = 0;
            idle_run = 0;
            prev_busy = 1'b0;
            prev_fd = 1'b0;
        end else begin
            if (busy_a && !prev_busy) begin
                frames_a++;
                last_gap = idle_run;
            end
            if (!busy_a && prev_busy) begin
                chk("busy_len", busy_run, 300);
                chk("frame_done_last", prev_fd, 1);
            end
            if (frame_done_a) done_a++;
            busy_run = busy_a ? busy_run + 1 : 0;
            idle_run = busy_a ? 0 : idle_run + 1;
            prev_busy = busy_a;
            prev_fd = frame_done_a;
        end
    end

    // Heartbeat instance: spacing between frame starts.
    int   last_start_b = -1;
    int   hb_checked = 0;
    logic prev_busy_b = 1'b0;
    always @(negedge clk) begin
        if (!rst_b && busy_b && !prev_busy_b) begin
            if (last_start_b >= 0) begin
                if (sp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL hb_unexpected actual=%0d required=none", cyc - last_start_b);
                end else begin
                    chk("hb_spacing", cyc - last_start_b, sp_q.pop_front());
                    hb_checked++;
                end
            end
            last_start_b = cyc;
        end
        prev_busy_b = busy_b;
    end

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy_a !== 1'b0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", busy_a, 0);
    endtask

    task automatic wait_frames(input int f, input int lim);
        int n = 0;
        while (frames_a < f && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("frame_count", frames_a, f);
    endtask

    task automatic pulse_fs;
        fs_a = 1'b1;
        @(negedge clk);
        fs_a = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_frame_done", frame_done_a, 0);
        push_frame(8'h18);
        repeat (20) sp_q.push_back(1000);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        chk("first_tx", tx_a, 0);
        chk("first_busy", busy_a, 1);
        wait_idle(400);
        chk("t1_frames", frames_a, 1);
        chk("t1_done", done_a, 1);
        chk("t1_tx_idle", tx_a, 1);

        repeat (3000) begin
            @(negedge clk);
            chk("t2_idle_line", {30'd0, busy_a, tx_a}, 32'd1);
        end
        chk("t2_frames", frames_a, 1);

        push_frame(8'h0C);
        push_frame(8'h06);
        bits_a = 8'h0C;
        wait_frames(2, 20);
        repeat (150) @(negedge clk);
        bits_a = 8'h06;
        wait_frames(3, 400);
        chk("t3_gap", last_gap, 1);
        wait_idle(400);
        chk("t3_done", done_a, 3);

        push_frame(8'h01);
        bits_a = 8'h01;
        wait_frames(4, 20);
        repeat (100) @(negedge clk);
        bits_a = 8'h02;
        repeat (50) @(negedge clk);
        bits_a = 8'h01;
        wait_idle(400);
        repeat (500) @(negedge clk);
        chk("t4_frames", frames_a, 4);

        push_frame(8'hC0);
        bits_a = 8'hC0;
        wait_frames(5, 20);
        wait_idle(400);
        repeat (20) @(negedge clk);
        push_frame(8'hC0);
        pulse_fs();
        wait_frames(6, 20);
        push_frame(8'hC0);
        repeat (40) @(negedge clk);
        pulse_fs();
        repeat (30) @(negedge clk);
        pulse_fs();
        repeat (30) @(negedge clk);
        pulse_fs();
        wait_idle(400);
        wait_frames(7, 20);
        wait_idle(400);
        repeat (500) @(negedge clk);
        chk("t5_frames", frames_a, 7);
        chk("t5_done", done_a, 7);

        push_frame(8'hC0);
        pulse_fs();
        wait_frames(8, 20);
        repeat (150) @(negedge clk);
        @(posedge clk);
        #2 rst_a = 1'b1;
        #1;
        chk("t6_rst_tx", tx_a, 1);
        chk("t6_rst_busy", busy_a, 0);
        exp_q.delete();
        push_frame(8'hC0);
        repeat (20) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        chk("t6_restart_tx", tx_a, 0);
        chk("t6_restart_busy", busy_a, 1);
        wait_idle(400);
        repeat (20) @(negedge clk);
        chk("t6_frames", frames_a, 9);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("hb_seen", hb_checked >= 3, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
